// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO in front of an 8N1 UART serialiser.
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Ports are the same with or without it.
//
// Ports:
//   clk       system clock, rising edge
//   resetn    asynchronous active-low reset
//   tx_valid  producer presents a byte on tx_data
//   tx_data   byte to enqueue (sampled only on an accepting edge)
//   tx_ready  FIFO not full
//   tx        serial line, idle high, registered
//   busy      FIFO non-empty or a frame in flight
//   level     FIFO occupancy
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 2500,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tx_valid,
  input  logic [7:0]                   tx_data,
  output logic                         tx_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // ---------------- FIFO ----------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [2:0]  state;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = tx_valid && !full;
  assign pop   = (state == S_IDLE) && !empty;

  assign tx_ready = !full;
  assign level    = wr_ptr - rd_ptr;
  assign busy     = (state != S_IDLE) || !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointer reset discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // ---------------- serialiser ----------------
  logic [15:0] baud;
  logic [2:0]  bit_cnt;
  logic [7:0]  data_q;
  logic        tx_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            data_q <= mem[rd_ptr[AW-1:0]];
            baud   <= BAUD_MAX;
            state  <= S_START;
          end
        end
        S_START: begin
          if (baud == '0) begin
            baud    <= BAUD_MAX;
            bit_cnt <= '0;
            state   <= S_DATA;
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_DATA: begin
          if (baud == '0) begin
            baud <= BAUD_MAX;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud == '0) begin
            baud  <= BAUD_MAX;
            state <= S_STOP;
          end else begin
            baud <= baud - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud == '0) state <= S_IDLE;
          else            baud  <= baud - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The line level is a registered copy of the current state's bit, so
  // the start bit appears one edge after the pop.
  always_comb begin
    tx_next = 1'b1;
    case (state)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = data_q[bit_cnt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = ^data_q;
`endif
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tx <= 1'b1;
    else         tx <= tx_next;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them as 8N1 frames (optionally 8E1) on a single TX line. It is the transmit-side companion to the SoM UART receive path. It lets fabric logic (sensor readout, debug dumps) push bursts of bytes to the host without tracking per-byte transmit timing. It runs directly from the UP_HSOSC system clock.

## Interface
Parameters:
- CLKS_PER_BIT, 2500: clk cycles per serial bit (24 MHz / 9600 baud); legal range 2..65535.
- FIFO_DEPTH, 16: byte entries; power of two, 2..256.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tx_valid  in  1  producer has a byte on tx_data.
- tx_data  in  8  byte to enqueue.
- tx_ready  out  1  FIFO can accept; high = not full.
- tx  out  1  serial line; idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Write: a byte is enqueued on any rising edge where tx_valid && tx_ready. tx_data is sampled only on that edge.
- FIFO: registered read/write pointers, one bit wider than the address. Full when the addresses are equal and the MSBs differ. Empty when the pointers are equal. Pointers wrap modulo 2·FIFO_DEPTH.
- Serialiser FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit counter runs 0..7. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY (build option only): tx = XOR of the 8 data bits, held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: 16-bit, counts CLKS_PER_BIT-1 down to 0. It reloads on every state or bit advance.
- Back-to-back frames: IDLE lasts exactly 1 cycle between consecutive frames when the FIFO is non-empty. Gap between the end of STOP and the next start bit = 1 clk.
- Simultaneous write and pop on the same edge: both take effect; level is unchanged.
- Write while full: ignored (tx_ready=0), no data corruption. tx_ready rises the cycle after a pop frees a slot.
- busy = (state != IDLE) || !empty.
- level = wr_ptr - rd_ptr (pointer width).

## Timing
- Reset values: tx=1, tx_ready=1, busy=0, level=0, FSM=IDLE, pointers=0. Applied asynchronously on resetn low.
- Reset mid-frame: the frame is aborted, tx returns high immediately, and FIFO contents are discarded. Operation resumes on the first edge after resetn deasserts.
- Latency: a byte written at edge N into an empty, idle block is popped at edge N+1; tx falls (start bit) after edge N+2.
- Frame length: 10·CLKS_PER_BIT cycles (11· with parity).
- tx is driven from a register; no combinational path from inputs to tx.
- tx_ready and level are registered-pointer functions: they update the edge after the write or pop.
- The last stop bit ends, and busy falls, at the edge where STOP completes with the FIFO empty.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present and frames are 8E1, 11 bits.
- Undefined: the PARITY state and XOR logic are compiled out and frames are 8N1, 10 bits.
- Defining the macro has no effect on any port.

## Test plan
Test benches use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Single byte 0x55 → tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. Total 40 cycles. busy falls at the end. With parity: an extra bit 0 before stop, 44 cycles.
- Burst of 0xA3, 0x0F, 0xFF written on consecutive cycles → three frames, each 1 idle cycle apart, decoded as those values in order. level peaks at 2.
- Write 5 bytes with tx_valid held high → tx_ready drops once level=4. The 5th byte is accepted only after the first pop. All 5 bytes emerge in order.
- Write on the same edge as a pop while level=4 is not possible (tx_ready=0). At level=2, write and pop on one edge → level stays 2 and data order is preserved.
- Assert resetn low during bit 3 of 0xC6 with 2 bytes queued → tx=1 the same cycle, level=0, busy=0. After release, a new byte 0x12 transmits correctly.
- Idle check: no writes for 1000 cycles → tx constant 1, busy=0, tx_ready=1.
